// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and result constants for the iterative comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam cmp_res_t RES_GT   = 3'b100;
    localparam cmp_res_t RES_EQ   = 3'b010;
    localparam cmp_res_t RES_LT   = 3'b001;
    localparam cmp_res_t RES_NONE = 3'b000;

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational CHUNK-bit magnitude comparator (MSB-first priority chain)
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    logic hi_eq;

    // A bit decides only when every more significant bit was equal.
    always_comb begin
        gt_o  = 1'b0;
        lt_o  = 1'b0;
        hi_eq = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            gt_o  = gt_o | (hi_eq & a_i[i] & ~b_i[i]);
            lt_o  = lt_o | (hi_eq & ~a_i[i] & b_i[i]);
            hi_eq = hi_eq & ~(a_i[i] ^ b_i[i]);
        end
        eq_o = hi_eq;
    end

endmodule

// File: rtl/iter_comparator.sv
// rtl/iter_comparator.sv - slice-serial magnitude comparator, MSB first with early exit
// Optional two's-complement mode is built only when CMP_SIGNED_EN is defined.
module iter_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    cmp_state_t       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    cmp_res_t         res_q;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             s_gt;
    logic             s_eq;
    logic             s_lt;
    logic             accept;

`ifdef CMP_SIGNED_EN
    logic signed_q;
`else
    logic unused_signed;
    assign unused_signed = signed_i;
`endif

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign gt        = res_q.gt;
    assign eq        = res_q.eq;
    assign lt        = res_q.lt;

    // Flipping the top sign bit maps two's-complement onto offset-binary order.
    always_comb begin
        slice_a = a_q[idx_q*CHUNK +: CHUNK];
        slice_b = b_q[idx_q*CHUNK +: CHUNK];
`ifdef CMP_SIGNED_EN
        if (signed_q && (idx_q == IDX_TOP)) begin
            slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
            slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
        end
`endif
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .gt_o (s_gt),
        .eq_o (s_eq),
        .lt_o (s_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= RES_NONE;
`ifdef CMP_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                idx_q    <= IDX_TOP;
`ifdef CMP_SIGNED_EN
                signed_q <= signed_i;
`endif
            end
            case (state_q)
                ST_IDLE: if (accept) state_q <= ST_RUN;
                ST_RUN: begin
                    if (!s_eq) begin
                        res_q   <= s_gt ? RES_GT : (s_lt ? RES_LT : RES_NONE);
                        state_q <= ST_DONE;
                    end else if (idx_q == '0) begin
                        res_q   <= RES_EQ;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                ST_DONE: if (out_ready) state_q <= accept ? ST_RUN : ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_comparator.sv
// tb/tb_iter_comparator.sv - directed and random checks of iter_comparator against a value-level model
module tb_iter_comparator;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_i = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             gt;
    logic             eq;
    logic             lt;

    int total = 0;
    int bad   = 0;

    iter_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .signed_i  (signed_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt)
    );

    always #5 clk = ~clk;

`ifdef CMP_SIGNED_EN
    localparam bit SIGNED_BUILT = 1'b1;
`else
    localparam bit SIGNED_BUILT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value-level reference: ordering from integer compare, latency from the highest differing bit.
    task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s,
                         output logic [2:0] res, output int k);
        int sa, sb, p;
        if (s && SIGNED_BUILT) begin
            sa = int'($signed(av));
            sb = int'($signed(bv));
        end else begin
            sa = int'({16'd0, av});
            sb = int'({16'd0, bv});
        end
        res = (sa > sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
        p = -1;
        for (int i = 0; i < WIDTH; i++)
            if (av[i] != bv[i]) p = i;
        k = (p < 0) ? NCHUNK : NCHUNK - p / CHUNK;
    endtask

    // Called right after the accepting edge (#1 past it); counts edges until out_valid.
    task automatic wait_result(input logic [2:0] er, input int ek, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 40);
        chk({tag, "_lat"}, n, ek);
        chk({tag, "_res"}, {gt, eq, lt}, er);
        chk({tag, "_busy"}, in_ready, 1'b0);
    endtask

    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s,
                          input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, in_ready, 1'b1);
        a = av;
        b = bv;
        signed_i = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_drain"}, out_valid, 1'b0);
    endtask

    task automatic run(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s,
                       input logic [2:0] er, input int ek, input string tag);
        launch(av, bv, s, tag);
        wait_result(er, ek, tag);
        drain(tag);
    endtask

    initial begin
        logic [2:0]       er;
        int               ek;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        logic [2:0]       held;

        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flags", {gt, eq, lt}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'h1234, 16'h1234, 1'b0, 3'b010, 4, "eq_1234");
        run(16'h9000, 16'h1FFF, 1'b0, 3'b100, 1, "u_9000");
        run(16'h9000, 16'h1FFF, 1'b1, SIGNED_BUILT ? 3'b001 : 3'b100, 1, "s_9000");
        run(16'h1235, 16'h1234, 1'b0, 3'b100, 4, "gt_1235");
        run(16'h1204, 16'h1234, 1'b0, 3'b001, 3, "lt_1204");
        run(16'h7FFF, 16'h8000, 1'b1, SIGNED_BUILT ? 3'b100 : 3'b001, 1, "s_7fff");
        run(16'hFFFF, 16'h0000, 1'b1, SIGNED_BUILT ? 3'b001 : 3'b100, 1, "s_ffff");

        // Backpressure then back-to-back acceptance in DONE.
        launch(16'h9000, 16'h1FFF, 1'b0, "bp");
        wait_result(3'b100, 1, "bp");
        held = {gt, eq, lt};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_flags", {gt, eq, lt}, 3'b100);
            chk("bp_hold_ready", in_ready, 1'b0);
        end
        a = 16'h1235;
        b = 16'h1234;
        signed_i = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 chk("bp_b2b_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_b2b_run_valid", out_valid, 1'b0);
        chk("bp_b2b_run_ready", in_ready, 1'b0);
        chk("bp_b2b_flags_kept", {gt, eq, lt}, held);
        wait_result(3'b100, 4, "bp_b2b");
        drain("bp_b2b");

        // Reset while the second slice is being evaluated.
        launch(16'h1234, 16'h1234, 1'b0, "rst_mid");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_flags", {gt, eq, lt}, 3'b000);
        chk("rst_mid_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(16'h1204, 16'h1234, 1'b0, 3'b001, 3, "post_rst");

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, WIDTH - 1));
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, er, ek);
            run(ra, rb, rs, er, ek, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
